// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM state type and request layout for the memory request controller
//
// Purpose : single home for the default bus widths, the controller state enum
//           and the packed request record carried through the request buffer.
// Contents: ADDR_W, DATA_W, FIFO_DEPTH defaults; state_t {IDLE, ACCESS, RECOVER};
//           mem_req_t {write, addr, wdata}.

package mem_pkg;

   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - request buffer, power-of-two depth, extra-bit pointers
//
// Purpose : holds accepted requests until the controller FSM issues them.
// Ports   : clk, rst (async, active-high)
//           push, push_data : write one entry (ignored when full)
//           pop,  pop_data  : remove head entry (ignored when empty); pop_data
//                             always shows the current head
//           full, empty     : occupancy flags

module mem_req_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   // The top pointer bit flips on every lap, so equal low bits with differing
   // top bits means the writer is a full lap ahead.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = store[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Payload storage needs no reset: only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - buffered single-port memory request controller
//
// Purpose : accepts read/write requests into a small buffer and issues them to a
//           synchronous memory one at a time (ACCESS strobe cycle followed by a
//           RECOVER cycle), returning read data in acceptance order.
// Ports   : clk, rst (async, active-high)
//           req_valid/req_ready, req_write, req_addr, req_wdata : request in
//           rsp_valid, rsp_addr, rsp_data                      : read response out
//           mem_read, mem_write, mem_addr, mem_data_in         : memory drive
//           mem_data_out                                       : memory read data (1-cycle latency)
//           busy                                               : work buffered or in flight

module mem_req_ctrl #(
   parameter int ADDR_W     = mem_pkg::ADDR_W,
   parameter int DATA_W     = mem_pkg::DATA_W,
   parameter int FIFO_DEPTH = mem_pkg::FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   mem_pkg::state_t   state;
   mem_pkg::state_t   state_nx;
   mem_pkg::mem_req_t push_req;
   mem_pkg::mem_req_t head_req;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;

   logic              cur_read;
   logic              cur_read_nx;
   logic              mem_read_nx;
   logic              mem_write_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [DATA_W-1:0] mem_data_in_nx;
   logic              rsp_valid_nx;
   logic [ADDR_W-1:0] rsp_addr_nx;
   logic [DATA_W-1:0] rsp_data_nx;

   // Ready depends only on occupancy, so a pop on the same edge never frees room
   // for a push into a full buffer.
   assign req_ready = !fifo_full;
   assign fifo_push = req_valid && req_ready;
   assign busy      = !fifo_empty || (state != mem_pkg::IDLE);

   always_comb begin
      push_req       = '0;
      push_req.write = req_write;
      push_req.addr  = req_addr;
      push_req.wdata = req_wdata;
   end

   mem_req_fifo #(
      .WIDTH ($bits(mem_pkg::mem_req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_req),
      .pop       (fifo_pop),
      .pop_data  (head_req),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= mem_pkg::IDLE;
         cur_read    <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         rsp_valid   <= 1'b0;
         rsp_addr    <= '0;
         rsp_data    <= '0;
      end else begin
         state       <= state_nx;
         cur_read    <= cur_read_nx;
         mem_read    <= mem_read_nx;
         mem_write   <= mem_write_nx;
         mem_addr    <= mem_addr_nx;
         mem_data_in <= mem_data_in_nx;
         rsp_valid   <= rsp_valid_nx;
         rsp_addr    <= rsp_addr_nx;
         rsp_data    <= rsp_data_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      cur_read_nx    = cur_read;
      mem_read_nx    = 1'b0;
      mem_write_nx   = 1'b0;
      mem_addr_nx    = mem_addr;
      mem_data_in_nx = mem_data_in;
      rsp_valid_nx   = 1'b0;
      rsp_addr_nx    = rsp_addr;
      rsp_data_nx    = rsp_data;
      fifo_pop       = 1'b0;

      case (state)
         mem_pkg::IDLE, mem_pkg::RECOVER: begin
            // mem_addr still holds the address of the access just finished, and
            // the memory presents its read data during this RECOVER cycle.
            if ((state == mem_pkg::RECOVER) && cur_read) begin
               rsp_valid_nx = 1'b1;
               rsp_addr_nx  = mem_addr;
               rsp_data_nx  = mem_data_out;
            end
            if (!fifo_empty) begin
               fifo_pop       = 1'b1;
               mem_addr_nx    = head_req.addr;
               mem_data_in_nx = head_req.wdata;
               mem_write_nx   = head_req.write;
               mem_read_nx    = !head_req.write;
               cur_read_nx    = !head_req.write;
               state_nx       = mem_pkg::ACCESS;
            end else begin
               state_nx = mem_pkg::IDLE;
            end
         end
         mem_pkg::ACCESS: begin
            // Strobes default low here, so the strobe lasts exactly one cycle.
            state_nx = mem_pkg::RECOVER;
         end
         default: begin
            state_nx = mem_pkg::IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl

module tb_mem_req_ctrl;

   localparam int AW = 5;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_data;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;
   logic          busy;

   always #5 clk = ~clk;

   mem_req_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_addr     (rsp_addr),
      .rsp_data     (rsp_data),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .busy         (busy)
   );

   // Synchronous memory with one-cycle read latency.
   logic [DW-1:0] mem [32];
   logic [DW-1:0] rd_q = '0;
   initial for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_data_in;
      if (mem_read)  rd_q <= mem[mem_addr];
   end
   assign mem_data_out = rd_q;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event logs built at the falling edge.
   int            s_cyc [$];
   logic          s_w   [$];
   logic [AW-1:0] s_a   [$];
   logic [DW-1:0] s_d   [$];
   int            r_cyc [$];
   logic [AW-1:0] r_a   [$];
   logic [DW-1:0] r_d   [$];

   int   n_acc     = 0;
   int   last_acc  = 0;
   logic drop_arm  = 1'b0;
   int   drop_q    = -1;
   logic prev_stb  = 1'b0;
   logic prev_rsp  = 1'b0;

   always @(negedge clk) begin
      check_eq("rd_wr_exclusive", int'(mem_read && mem_write), 0);
      check_eq("strobe_gap", int'(prev_stb && (mem_read || mem_write)), 0);
      check_eq("rsp_single_cycle", int'(prev_rsp && rsp_valid), 0);
      prev_stb = mem_read || mem_write;
      prev_rsp = rsp_valid;
      if (mem_read || mem_write) begin
         s_cyc.push_back(cyc);
         s_w.push_back(mem_write);
         s_a.push_back(mem_addr);
         s_d.push_back(mem_data_in);
      end
      if (rsp_valid) begin
         r_cyc.push_back(cyc);
         r_a.push_back(rsp_addr);
         r_d.push_back(rsp_data);
      end
      if (drop_arm && !req_ready && drop_q < 0)
         drop_q = n_acc - s_cyc.size();
   end

   // Called at a falling edge; leaves req_valid asserted and returns at the
   // falling edge after the accepting clock edge.
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) check_eq("ready_timeout", 0, 1);
      @(posedge clk);
      n_acc++;
      @(negedge clk);
      last_acc = cyc;
   endtask

   task automatic idle_wait();
      int t;
      req_valid = 1'b0;
      t = 0;
      while (busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_eq("idle_reached", int'(busy), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      int sb;
      int rb;
      int t;
      logic found;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", int'(req_ready), 1);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_mem_read", int'(mem_read), 0);
      check_eq("rst_mem_write", int'(mem_write), 0);
      check_eq("rst_mem_addr", int'(mem_addr), 0);
      check_eq("rst_mem_data_in", int'(mem_data_in), 0);
      check_eq("rst_rsp_valid", int'(rsp_valid), 0);
      check_eq("rst_rsp_addr", int'(rsp_addr), 0);
      check_eq("rst_rsp_data", int'(rsp_data), 0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_req_ready", int'(req_ready), 1);
      @(negedge clk);

      // Write A5 @3 then read @3
      sb = s_cyc.size();
      rb = r_cyc.size();
      send(1'b1, 5'd3, 8'hA5);
      send(1'b0, 5'd3, 8'h00);
      idle_wait();
      check_eq("t1_strobes", s_cyc.size() - sb, 2);
      check_eq("t1_wr_kind", int'(s_w[sb]), 1);
      check_eq("t1_wr_addr", int'(s_a[sb]), 3);
      check_eq("t1_wr_data", int'(s_d[sb]), 'hA5);
      check_eq("t1_rd_kind", int'(s_w[sb+1]), 0);
      check_eq("t1_rd_addr", int'(s_a[sb+1]), 3);
      check_eq("t1_rsp_count", r_cyc.size() - rb, 1);
      check_eq("t1_rsp_addr", int'(r_a[rb]), 3);
      check_eq("t1_rsp_data", int'(r_d[rb]), 'hA5);

      // 8 back-to-back requests: even = write (8+i, 40+i), odd = read of previous
      sb = s_cyc.size();
      rb = r_cyc.size();
      drop_q   = -1;
      drop_arm = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) send(1'b1, AW'(8 + i), DW'(8'h40 + i));
         else            send(1'b0, AW'(8 + i - 1), 8'h00);
      end
      idle_wait();
      drop_arm = 1'b0;
      check_eq("t2_ready_drop_at_4", drop_q, 4);
      check_eq("t2_strobes", s_cyc.size() - sb, 8);
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("t2_kind_%0d", i), int'(s_w[sb+i]), (i % 2 == 0) ? 1 : 0);
         check_eq($sformatf("t2_addr_%0d", i), int'(s_a[sb+i]), 8 + i - (i % 2));
         if (i % 2 == 0) check_eq($sformatf("t2_data_%0d", i), int'(s_d[sb+i]), 'h40 + i);
         if (i > 0) check_eq($sformatf("t2_spacing_%0d", i), s_cyc[sb+i] - s_cyc[sb+i-1], 2);
      end
      check_eq("t2_rsp_count", r_cyc.size() - rb, 4);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("t2_rsp_addr_%0d", k), int'(r_a[rb+k]), 8 + 2 * k);
         check_eq($sformatf("t2_rsp_data_%0d", k), int'(r_d[rb+k]), 'h40 + 2 * k);
      end

      // Boundary addresses 31, 0, 16
      rb = r_cyc.size();
      send(1'b1, 5'd31, 8'hFF);
      send(1'b1, 5'd0,  8'h00);
      send(1'b1, 5'd16, 8'h3C);
      send(1'b0, 5'd31, 8'h00);
      send(1'b0, 5'd0,  8'h00);
      send(1'b0, 5'd16, 8'h00);
      idle_wait();
      check_eq("t3_rsp_count", r_cyc.size() - rb, 3);
      check_eq("t3_rsp0_addr", int'(r_a[rb]), 31);
      check_eq("t3_rsp0_data", int'(r_d[rb]), 'hFF);
      check_eq("t3_rsp1_addr", int'(r_a[rb+1]), 0);
      check_eq("t3_rsp1_data", int'(r_d[rb+1]), 'h00);
      check_eq("t3_rsp2_addr", int'(r_a[rb+2]), 16);
      check_eq("t3_rsp2_data", int'(r_d[rb+2]), 'h3C);

      // Reset during ACCESS of a write with three requests queued (last is a read)
      for (int i = 0; i < 5; i++) send(1'b1, AW'(20 + i), DW'(8'h11 * (i + 1)));
      send(1'b0, 5'd20, 8'h00);
      req_valid = 1'b0;
      found = 1'b0;
      t = 0;
      while (!found && t < 20) begin
         #1;
         if (mem_write && (n_acc - s_cyc.size() == 3)) found = 1'b1;
         else begin
            @(negedge clk);
            t++;
         end
      end
      check_eq("t4_write_access_with_3_queued", int'(found), 1);
      rst = 1'b1;
      #1;
      check_eq("t4_mem_write_async_low", int'(mem_write), 0);
      check_eq("t4_mem_read_low", int'(mem_read), 0);
      check_eq("t4_busy_low", int'(busy), 0);
      check_eq("t4_req_ready_high", int'(req_ready), 1);
      sb = s_cyc.size();
      rb = r_cyc.size();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("t4_no_rsp_after_rst", r_cyc.size() - rb, 0);
      check_eq("t4_no_strobe_after_rst", s_cyc.size() - sb, 0);
      check_eq("t4_idle_after_rst", int'(busy), 0);

      // 20 idle cycles, then a lone read of addr 7 from an empty, idle controller
      send(1'b1, 5'd7, 8'h5C);
      idle_wait();
      sb = s_cyc.size();
      repeat (20) @(negedge clk);
      check_eq("t5_no_idle_strobes", s_cyc.size() - sb, 0);
      rb = r_cyc.size();
      send(1'b0, 5'd7, 8'h00);
      req_valid = 1'b0;
      t = 0;
      while (r_cyc.size() == rb && t < 20) begin
         @(negedge clk);
         t++;
      end
      check_eq("t5_rsp_count", r_cyc.size() - rb, 1);
      check_eq("t5_rsp_addr", int'(r_a[rb]), 7);
      check_eq("t5_rsp_data", int'(r_d[rb]), 'h5C);
      // rsp_valid must be high in the 4th cycle counted from the accept edge
      check_eq("t5_latency", r_cyc[rb] - last_acc + 1, 4);
      idle_wait();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory address width (32 locations).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request buffer entries (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, forming the request handshake.
REQ-007 SHALL have ports req_write input 1 (1=write, 0=read), req_addr input ADDR_W, req_wdata input DATA_W.
REQ-008 SHALL have ports rsp_valid output 1, rsp_addr output ADDR_W, rsp_data output DATA_W, the read-response bus with no backpressure.
REQ-009 SHALL have ports mem_read output 1, mem_write output 1, mem_addr output ADDR_W, mem_data_in output DATA_W, which drive the memory.
REQ-010 SHALL have port mem_data_out input DATA_W, the memory read data.
REQ-011 SHALL have port busy output 1, high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-012 SHALL accept a request on a posedge where req_valid and req_ready are both 1, and push it into the FIFO.
REQ-013 SHALL drive req_ready = !fifo_full, so a push is refused when full even if a pop occurs on the same edge.
REQ-014 SHALL use FSM states IDLE, ACCESS and RECOVER.
REQ-015 SHALL, in IDLE or RECOVER with the FIFO non-empty, pop the head, register mem_addr, mem_data_in and the matching strobe, and go to ACCESS; otherwise it SHALL go to IDLE.
REQ-016 SHALL, in ACCESS, hold exactly one strobe high for exactly one cycle, then clear it and go to RECOVER.
REQ-017 SHALL never assert mem_read and mem_write together, and SHALL never assert strobes in consecutive cycles (minimum one low cycle between them).
REQ-018 SHALL treat memory read latency as 1 cycle: mem_data_out is valid in the RECOVER cycle after a read strobe.
REQ-019 SHALL, on the edge ending RECOVER of a read, load rsp_data <= mem_data_out and rsp_addr <= the read address, and pulse rsp_valid for exactly 1 cycle.
REQ-020 SHALL produce no response for writes; requests SHALL complete strictly in acceptance order.
REQ-021 SHALL give a read with an empty FIFO and FSM IDLE a latency of 4 cycles from the accept edge to the rsp_valid-high cycle, and SHALL sustain 1 operation per 2 cycles.
REQ-022 SHALL hold mem_addr and mem_data_in at their last values while idle, and SHALL mask addresses to ADDR_W bits (31 -> 0 is a plain wrap, with no special case).
REQ-023 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, using an extra pointer bit to distinguish full from empty.

Reset
REQ-024 SHALL, while rst is high, asynchronously force: state IDLE, FIFO empty, mem_read=0, mem_write=0, mem_addr=0, mem_data_in=0, rsp_valid=0, rsp_addr=0, rsp_data=0, busy=0.
REQ-025 SHALL drive req_ready=1 during and immediately after reset.
REQ-026 SHALL silently discard any operation in flight or buffered when rst asserts mid-operation, with no response issued.

Structure
REQ-027 SHALL take ADDR_W, DATA_W, the state enum (IDLE/ACCESS/RECOVER) and a request struct {write, addr, wdata} from shared package mem_pkg.
REQ-028 SHALL instantiate the request buffer as sub-module mem_req_fifo (push/pop, full/empty, async active-high rst); the FSM and output registers SHALL live in mem_req_ctrl.

Verification
REQ-029 SHALL verify write A5 to addr 3, then read addr 3 -> mem_write high 1 cycle with mem_addr=3 and mem_data_in=A5; rsp_valid 1 cycle with rsp_addr=3, rsp_data=A5.
REQ-030 SHALL verify 8 back-to-back requests held valid -> req_ready drops once 4 are buffered, all 8 are executed in order, and the strobes are spaced exactly 2 cycles apart.
REQ-031 SHALL verify write FF@31, 00@0, 3C@16, then read 31, 0, 16 -> responses FF, 00, 3C in that order.
REQ-032 SHALL verify rst asserted during the ACCESS cycle of a write with 3 requests queued -> mem_write falls without waiting for a clock edge, busy=0, req_ready=1, and no rsp_valid follows.
REQ-033 SHALL verify 20 idle cycles, then a single read of addr 7 -> no strobes during the idle cycles, and a response exactly 4 cycles after accept.
REQ-034 SHALL run continuous assertions throughout: !(mem_read && mem_write); no strobe in 2 consecutive cycles; rsp_valid never high for 2 consecutive cycles.
